// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M/RV64M multiply/divide engine for the EX stage.
// Multiplies use radix-2 shift-add and divides use restoring division, both on operand
// magnitudes with signs applied in DONE. Divide-by-zero, signed overflow and reserved
// ops finish without iterating.
// Optional feature macro: MUL_DIV_FAST_MUL_EN (single-cycle combinational multiplies).
`ifndef XLEN
`define XLEN 32
`endif

module mul_div_unit #(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [3:0]      mul_div_op,
    input  logic            is_word_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy
);
    localparam int CW    = $clog2(XLEN);
    localparam bit HAS_W = (XLEN == 64);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [2*XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              word_in, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_val;
    logic [2*XLEN-1:0] mul_sum, prod;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_new, raw_res, final_res;
    logic [CW-1:0]     last_cnt;
    logic              busy_c;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] t;
        t = x;
        return XLEN'(t);
    endfunction

    // Operand preparation: W truncation/extension, sign detection and magnitudes
    always_comb begin
        word_in  = HAS_W && is_word_op;
        a_signed = (mul_div_op == 4'd0) || (mul_div_op == 4'd1) || (mul_div_op == 4'd2) ||
                   (mul_div_op == 4'd4) || (mul_div_op == 4'd6);
        b_signed = (mul_div_op == 4'd0) || (mul_div_op == 4'd1) ||
                   (mul_div_op == 4'd4) || (mul_div_op == 4'd6);
        ext_a    = operand_a;
        ext_b    = operand_b;
        if (word_in) begin
            ext_a = a_signed ? sext32(operand_a[31:0]) : XLEN'(operand_a[31:0]);
            ext_b = b_signed ? sext32(operand_b[31:0]) : XLEN'(operand_b[31:0]);
        end
        a_neg    = a_signed && ext_a[XLEN-1];
        b_neg    = b_signed && ext_b[XLEN-1];
        mag_a    = a_neg ? -ext_a : ext_a;
        mag_b    = b_neg ? -ext_b : ext_b;
        min_val  = word_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step of shift-add multiply and restoring divide, plus the DONE result
    always_comb begin
        mul_sum  = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_new  = rem_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
        last_cnt = word_q ? CW'(31) : CW'(XLEN-1);
        prod     = neg_q ? -acc_q : acc_q;
        case (op_q)
            4'd0:                raw_res = prod[XLEN-1:0];
            4'd1, 4'd2, 4'd3:    raw_res = word_q ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
            4'd4, 4'd5:          raw_res = neg_q ? -a_q[XLEN-1:0] : a_q[XLEN-1:0];
            4'd6, 4'd7:          raw_res = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            default:             raw_res = '0;
        endcase
        if (spec_q) begin
            raw_res = acc_q[XLEN-1:0];
        end
        final_res = word_q ? sext32(raw_res[31:0]) : raw_res;
    end

    // Next-state and datapath control for IDLE -> COMPUTE/DONE -> IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        op_d     = op_q;
        word_d   = word_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        spec_d   = spec_q;
        result_d = result_q;
        busy_c   = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    busy_c = 1'b1;
                    op_d   = mul_div_op;
                    word_d = word_in;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    spec_d = 1'b0;
                    a_d    = '0;
                    b_d    = '0;
                    acc_d  = '0;
                    if (mul_div_op[3]) begin
                        spec_d  = 1'b1;
                        state_d = DONE;
                    end else if (mul_div_op[2] && (ext_b == '0)) begin
                        spec_d  = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, (mul_div_op[1] ? ext_a : {XLEN{1'b1}})};
                        state_d = DONE;
                    end else if (mul_div_op[2] && !mul_div_op[0] && (ext_a == min_val) &&
                                 (ext_b == {XLEN{1'b1}})) begin
                        spec_d  = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, (mul_div_op[1] ? {XLEN{1'b0}} : ext_a)};
                        state_d = DONE;
                    end else if (mul_div_op[2]) begin
                        a_d     = {{XLEN{1'b0}}, (word_in ? (mag_a << (XLEN - 32)) : mag_a)};
                        b_d     = mag_b;
                        state_d = COMPUTE;
                    end else begin
`ifdef MUL_DIV_FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                        state_d = DONE;
`else
                        a_d     = {{XLEN{1'b0}}, mag_a};
                        b_d     = mag_b;
                        state_d = COMPUTE;
`endif
                    end
                end
            end
            COMPUTE: begin
                busy_c = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (!op_q[2]) begin
                    acc_d = mul_sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = {{XLEN{1'b0}}, rem_new};
                    a_d   = {{XLEN{1'b0}}, a_q[XLEN-2:0], rem_ge};
                end
                if (cnt_q == last_cnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready    = 1'b1;
                result_d = final_res;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    assign busy   = busy_c && reset_n;
    assign result = (state_q == DONE) ? final_res : result_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, captured operation, operand/accumulator and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            word_q   <= word_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            spec_q   <= spec_d;
            result_q <= result_d;
        end
    end

endmodule
